// File: rtl/pipe_ctrl.sv
// Pipeline sequencer: taken-branch flush, multi-cycle MUL hold, and HLT/resume.
// Optional performance counters are enabled with `define PIPE_CTRL_PERF_EN.
module pipe_ctrl #(
    parameter int unsigned OPCODE_W    = 16,
    parameter int unsigned PC_W        = 32,
    parameter int unsigned MUL_LAT     = 3,
    parameter int unsigned FLUSH_DEPTH = 2
) (
    input  logic                clock,
    input  logic                reset_n,
    input  logic                ex_valid,
    input  logic [OPCODE_W-1:0] ex_opcode,
    input  logic                ex_branch_taken,
    input  logic [PC_W-1:0]     ex_branch_target,
    input  logic                resume,
    output logic                stall,
    output logic                flush,
    output logic                pc_load,
    output logic [PC_W-1:0]     pc_load_value,
    output logic                halted,
    output logic [1:0]          state,
    output logic [31:0]         stall_cycles,
    output logic [31:0]         flush_cycles
);

    localparam int unsigned CNT_W = 4;
    localparam logic [OPCODE_W-1:0] OP_BR_A = OPCODE_W'(9);
    localparam logic [OPCODE_W-1:0] OP_BR_B = OPCODE_W'(10);
    localparam logic [OPCODE_W-1:0] OP_MUL  = OPCODE_W'(13);
    localparam logic [OPCODE_W-1:0] OP_HLT  = OPCODE_W'(14);
    localparam bit                  MUL_MULTI    = (MUL_LAT > 1);
    localparam logic [CNT_W-1:0]    MUL_CNT_INIT = MUL_MULTI ? CNT_W'(MUL_LAT - 2) : '0;
    localparam logic [CNT_W-1:0]    FLS_CNT_INIT = CNT_W'(FLUSH_DEPTH - 1);

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_MULW  = 2'd1,
        ST_FLUSH = 2'd2,
        ST_HALT  = 2'd3
    } state_e;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             mul_guard_q, mul_guard_d;
    logic             hlt_guard_q, hlt_guard_d;
    logic             stall_q, stall_d;
    logic             flush_q, flush_d;
    logic             pc_load_q, pc_load_d;
    logic [PC_W-1:0]  pc_load_value_q, pc_load_value_d;
    logic             halted_q, halted_d;

    logic hlt_c, br_c, mul_c;

    // Guards suppress re-detection of the instruction still sitting in EX after a hold ends.
    assign hlt_c = ex_valid && (ex_opcode == OP_HLT) && !hlt_guard_q;
    assign br_c  = ex_valid && ex_branch_taken && ((ex_opcode == OP_BR_A) || (ex_opcode == OP_BR_B));
    assign mul_c = ex_valid && (ex_opcode == OP_MUL) && !mul_guard_q;

    always_comb begin
        state_d         = state_q;
        count_d         = count_q;
        mul_guard_d     = 1'b0;
        hlt_guard_d     = 1'b0;
        stall_d         = 1'b0;
        flush_d         = 1'b0;
        pc_load_d       = 1'b0;
        pc_load_value_d = pc_load_value_q;
        halted_d        = 1'b0;

        case (state_q)
            ST_RUN: begin
                if (hlt_c) begin
                    state_d  = ST_HALT;
                    stall_d  = 1'b1;
                    halted_d = 1'b1;
                end else if (br_c) begin
                    state_d         = ST_FLUSH;
                    pc_load_d       = 1'b1;
                    pc_load_value_d = ex_branch_target;
                    flush_d         = 1'b1;
                    count_d         = FLS_CNT_INIT;
                end else if (mul_c && MUL_MULTI) begin
                    state_d = ST_MULW;
                    stall_d = 1'b1;
                    count_d = MUL_CNT_INIT;
                end
            end
            ST_MULW: begin
                if (count_q == '0) begin
                    state_d     = ST_RUN;
                    mul_guard_d = 1'b1;
                end else begin
                    count_d = count_q - CNT_W'(1);
                    stall_d = 1'b1;
                end
            end
            ST_FLUSH: begin
                if (count_q == '0) begin
                    state_d = ST_RUN;
                end else begin
                    count_d = count_q - CNT_W'(1);
                    flush_d = 1'b1;
                end
            end
            ST_HALT: begin
                if (resume) begin
                    state_d     = ST_RUN;
                    hlt_guard_d = 1'b1;
                end else begin
                    stall_d  = 1'b1;
                    halted_d = 1'b1;
                end
            end
            default: state_d = ST_RUN;
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state_q         <= ST_RUN;
            count_q         <= '0;
            mul_guard_q     <= 1'b0;
            hlt_guard_q     <= 1'b0;
            stall_q         <= 1'b0;
            flush_q         <= 1'b0;
            pc_load_q       <= 1'b0;
            pc_load_value_q <= '0;
            halted_q        <= 1'b0;
        end else begin
            state_q         <= state_d;
            count_q         <= count_d;
            mul_guard_q     <= mul_guard_d;
            hlt_guard_q     <= hlt_guard_d;
            stall_q         <= stall_d;
            flush_q         <= flush_d;
            pc_load_q       <= pc_load_d;
            pc_load_value_q <= pc_load_value_d;
            halted_q        <= halted_d;
        end
    end

    assign stall         = stall_q;
    assign flush         = flush_q;
    assign pc_load       = pc_load_q;
    assign pc_load_value = pc_load_value_q;
    assign halted        = halted_q;
    assign state         = state_q;

`ifdef PIPE_CTRL_PERF_EN
    logic [31:0] stall_cycles_q, stall_cycles_d;
    logic [31:0] flush_cycles_q, flush_cycles_d;

    // Count cycles in which the registered strobes are high; wraps modulo 2^32.
    always_comb begin
        stall_cycles_d = stall_cycles_q + 32'(stall_q);
        flush_cycles_d = flush_cycles_q + 32'(flush_q);
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            stall_cycles_q <= '0;
            flush_cycles_q <= '0;
        end else begin
            stall_cycles_q <= stall_cycles_d;
            flush_cycles_q <= flush_cycles_d;
        end
    end

    assign stall_cycles = stall_cycles_q;
    assign flush_cycles = flush_cycles_q;
`else
    assign stall_cycles = 32'd0;
    assign flush_cycles = 32'd0;
`endif

endmodule

// File: tb/tb_pipe_ctrl.sv
// Bench for pipe_ctrl: directed scenarios plus random traffic against a cycle-count model.
module tb_pipe_ctrl;

    localparam int unsigned MUL_LAT     = 3;
    localparam int unsigned FLUSH_DEPTH = 2;

    logic        clock = 1'b0;
    logic        reset_n;
    logic        ex_valid;
    logic [15:0] ex_opcode;
    logic        ex_branch_taken;
    logic [31:0] ex_branch_target;
    logic        resume;
    logic        stall, flush, pc_load, halted;
    logic [31:0] pc_load_value, stall_cycles, flush_cycles;
    logic [1:0]  state;

    int errors = 0;
    int checks = 0;

    pipe_ctrl #(
        .OPCODE_W(16), .PC_W(32), .MUL_LAT(MUL_LAT), .FLUSH_DEPTH(FLUSH_DEPTH)
    ) dut (
        .clock(clock), .reset_n(reset_n), .ex_valid(ex_valid), .ex_opcode(ex_opcode),
        .ex_branch_taken(ex_branch_taken), .ex_branch_target(ex_branch_target),
        .resume(resume), .stall(stall), .flush(flush), .pc_load(pc_load),
        .pc_load_value(pc_load_value), .halted(halted), .state(state),
        .stall_cycles(stall_cycles), .flush_cycles(flush_cycles)
    );

    always #5 clock = ~clock;

    // Model: remaining cycles of each hold, plus one-cycle re-detection guards.
    int          m_flush_left = 0;
    int          m_mul_left   = 0;
    bit          m_halted     = 1'b0;
    bit          m_guard_mul  = 1'b0;
    bit          m_guard_hlt  = 1'b0;
    bit          m_pc_load    = 1'b0;
    logic [31:0] m_target     = '0;
    logic [31:0] m_stall_cnt  = '0;
    logic [31:0] m_flush_cnt  = '0;

    function automatic bit exp_stall();
        return m_halted || (m_mul_left > 0);
    endfunction

    function automatic bit exp_flush();
        return m_flush_left > 0;
    endfunction

    function automatic logic [1:0] exp_state();
        if (m_halted)          return 2'd3;
        if (m_flush_left > 0)  return 2'd2;
        if (m_mul_left > 0)    return 2'd1;
        return 2'd0;
    endfunction

    task automatic model_update();
        bit g_mul, g_hlt, is_hlt, is_br, is_mul;
        if (!reset_n) begin
            m_flush_left = 0; m_mul_left = 0; m_halted = 0;
            m_guard_mul = 0; m_guard_hlt = 0; m_pc_load = 0;
            m_target = '0; m_stall_cnt = '0; m_flush_cnt = '0;
            return;
        end
        m_stall_cnt = m_stall_cnt + 32'(exp_stall());
        m_flush_cnt = m_flush_cnt + 32'(exp_flush());
        g_mul = 0; g_hlt = 0; m_pc_load = 0;
        if (m_flush_left > 0) begin
            m_flush_left--;
        end else if (m_mul_left > 0) begin
            m_mul_left--;
            if (m_mul_left == 0) g_mul = 1;
        end else if (m_halted) begin
            if (resume) begin
                m_halted = 0;
                g_hlt = 1;
            end
        end else begin
            is_hlt = ex_valid && ex_opcode == 16'hE && !m_guard_hlt;
            is_br  = ex_valid && ex_branch_taken && (ex_opcode == 16'h9 || ex_opcode == 16'hA);
            is_mul = ex_valid && ex_opcode == 16'hD && !m_guard_mul;
            if (is_hlt) begin
                m_halted = 1;
            end else if (is_br) begin
                m_flush_left = FLUSH_DEPTH;
                m_pc_load = 1;
                m_target = ex_branch_target;
            end else if (is_mul && MUL_LAT > 1) begin
                m_mul_left = MUL_LAT - 1;
            end
        end
        m_guard_mul = g_mul;
        m_guard_hlt = g_hlt;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic compare_all();
        logic [31:0] e_sc, e_fc;
`ifdef PIPE_CTRL_PERF_EN
        e_sc = m_stall_cnt;
        e_fc = m_flush_cnt;
`else
        e_sc = '0;
        e_fc = '0;
`endif
        check("state", 32'(state), 32'(exp_state()));
        check("stall", 32'(stall), 32'(exp_stall()));
        check("flush", 32'(flush), 32'(exp_flush()));
        check("pc_load", 32'(pc_load), 32'(m_pc_load));
        check("pc_load_value", pc_load_value, m_target);
        check("halted", 32'(halted), 32'(m_halted));
        check("stall_cycles", stall_cycles, e_sc);
        check("flush_cycles", flush_cycles, e_fc);
    endtask

    // One clock: DUT and model consume the same inputs, then outputs are compared mid-cycle.
    task automatic step();
        @(posedge clock);
        model_update();
        @(negedge clock);
        compare_all();
    endtask

    task automatic drive(input logic v, input logic [15:0] op, input logic tk, input logic [31:0] tgt);
        ex_valid = v; ex_opcode = op; ex_branch_taken = tk; ex_branch_target = tgt;
    endtask

    task automatic run_branch_40();
        drive(1, 16'h9, 1, 32'h40);
        step();
        check("br_pc_load_on", 32'(pc_load), 32'd1);
        check("br_target", pc_load_value, 32'h40);
        check("br_state_flush", 32'(state), 32'd2);
        drive(0, 16'h0, 0, 32'h0);
        step();
        check("br_pc_load_off", 32'(pc_load), 32'd0);
        check("br_flush_2nd", 32'(flush), 32'd1);
        step();
        check("br_flush_done", 32'(flush), 32'd0);
        check("br_state_run", 32'(state), 32'd0);
    endtask

    task automatic run_mul_held();
        drive(1, 16'hD, 0, 32'h0);
        step();
        check("mul_stall_1", 32'(stall), 32'd1);
        check("mul_state", 32'(state), 32'd1);
        step();
        check("mul_stall_2", 32'(stall), 32'd1);
        step();
        check("mul_stall_end", 32'(stall), 32'd0);
        step();
        check("mul_no_restall", 32'(stall), 32'd0);
        drive(0, 16'h0, 0, 32'h0);
        step();
    endtask

    initial begin
        reset_n = 1'b0;
        resume  = 1'b0;
        drive(0, 16'h0, 0, 32'h0);
        @(negedge clock);
        step();
        step();
        check("rst_state", 32'(state), 32'd0);
        check("rst_stall", 32'(stall), 32'd0);

        // Reset mid-MULW
        reset_n = 1'b1;
        drive(1, 16'hD, 0, 32'h0);
        step();
        check("t1_in_mulw", 32'(state), 32'd1);
        reset_n = 1'b0;
        step();
        check("t1_state", 32'(state), 32'd0);
        check("t1_stall", 32'(stall), 32'd0);
        check("t1_pc_load", 32'(pc_load), 32'd0);
        check("t1_halted", 32'(halted), 32'd0);
        reset_n = 1'b1;
        drive(0, 16'h0, 0, 32'h0);
        step();

        run_branch_40();
        run_mul_held();

        // HLT held in EX across HALT and resume
        drive(1, 16'hE, 0, 32'h0);
        step();
        check("hlt_state", 32'(state), 32'd3);
        for (int i = 0; i < 10; i++) begin
            step();
            check("hlt_hold", 32'({halted, stall}), 32'd3);
        end
        resume = 1'b1;
        step();
        check("resume_halted", 32'(halted), 32'd0);
        check("resume_stall", 32'(stall), 32'd0);
        resume = 1'b0;
        step();
        check("no_rehalt", 32'(halted), 32'd0);
        drive(0, 16'h0, 0, 32'h0);
        step();

        // Untaken branch, then a second branch during FLUSH
        drive(1, 16'hA, 0, 32'h80);
        step();
        check("nt_flush", 32'(flush), 32'd0);
        check("nt_pc_load", 32'(pc_load), 32'd0);
        drive(1, 16'hA, 1, 32'h100);
        step();
        check("t5_pc_load", 32'(pc_load), 32'd1);
        drive(1, 16'hA, 1, 32'h200);
        step();
        check("t5_ignored_pc_load", 32'(pc_load), 32'd0);
        check("t5_value_kept", pc_load_value, 32'h100);
        step();
        check("t5_flush_done", 32'(flush), 32'd0);
        drive(0, 16'h0, 0, 32'h0);
        step();

        // Counters over a fresh branch + MUL sequence
        reset_n = 1'b0;
        step();
        reset_n = 1'b1;
        step();
        run_branch_40();
        run_mul_held();
`ifdef PIPE_CTRL_PERF_EN
        check("perf_flush", flush_cycles, 32'd2);
        check("perf_stall", stall_cycles, 32'd2);
`else
        check("perf_flush_off", flush_cycles, 32'd0);
        check("perf_stall_off", stall_cycles, 32'd0);
`endif

        for (int n = 0; n < 3000; n++) begin
            logic [15:0] op;
            case ($urandom_range(0, 5))
                0: op = 16'h9;
                1: op = 16'hA;
                2: op = 16'hD;
                3: op = 16'hE;
                4: op = 16'h0;
                default: op = 16'($urandom);
            endcase
            reset_n = ($urandom_range(0, 99) != 0);
            resume  = ($urandom_range(0, 7) == 0);
            drive(($urandom_range(0, 3) != 0), op, 1'($urandom_range(0, 1)), $urandom);
            step();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
